// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Holds RV32I funct3 codes, LSU state encoding and fault codes.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
   localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT_R,
      S_DONE
   } lsu_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Load data lane extraction and sign/zero extension.
// Purely combinational; shared by the LSU and its reference model.
module mem_load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] result_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed lane, then extend per funct3
   always_comb begin
      byte_v   = rdata_i[8*off_i +: 8];
      half_v   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      result_o = rdata_i;
      case (funct3_i)
         F3_LB:   result_o = {{24{byte_v[7]}}, byte_v};
         F3_LBU:  result_o = {24'h0, byte_v};
         F3_LH:   result_o = {{16{half_v[15]}}, half_v};
         F3_LHU:  result_o = {16'h0, half_v};
         default: result_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator over a req/ready + rvalid memory port.
// Stalls the pipeline per access and flags misaligned/illegal/timeout.
module mem_lsu
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   input  logic [1:0]        i_ctrlMEM,
   input  logic [2:0]        i_funct3,
   input  logic [ADDR_W-1:0] i_memAddr,
   input  logic [31:0]       i_writeData,
   output logic              o_memReq,
   output logic              o_memWe,
   output logic [ADDR_W-1:0] o_memAddrOut,
   output logic [31:0]       o_memWdata,
   output logic [3:0]        o_memBe,
   input  logic              i_memReady,
   input  logic              i_memRvalid,
   input  logic [31:0]       i_memRdata,
   output logic              o_stall,
   output logic [31:0]       o_readData,
   output logic              o_done,
   output logic [1:0]        o_fault
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   lsu_state_e        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              done_q, done_d;
   logic [1:0]        fault_q, fault_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic [31:0]       cnt_q, cnt_d;

   logic        access, is_wr, illegal, misalign, to_hit;
   logic [3:0]  be_new;
   logic [31:0] wd_new, ld_ext;

   mem_load_align u_align (
      .rdata_i  (i_memRdata),
      .off_i    (off_q),
      .funct3_i (f3_q),
      .result_o (ld_ext)
   );

   // Decode the incoming request: legality, alignment, lanes
   always_comb begin
      access   = i_valid & (i_ctrlMEM != 2'b00);
      is_wr    = (i_ctrlMEM == 2'b01);
      illegal  = (i_ctrlMEM == 2'b11)
               | (i_funct3 == 3'b011)
               | (i_funct3 == 3'b110)
               | (i_funct3 == 3'b111)
               | (is_wr & i_funct3[2]);
      misalign = ((i_funct3[1:0] == 2'b01) & i_memAddr[0])
               | ((i_funct3[1:0] == 2'b10) & (i_memAddr[1:0] != 2'b00));
      be_new   = 4'b1111;
      wd_new   = i_writeData;
      if (is_wr) begin
         case (i_funct3[1:0])
            2'b00: begin
               be_new = 4'b0001 << i_memAddr[1:0];
               wd_new = {4{i_writeData[7:0]}};
            end
            2'b01: begin
               be_new = i_memAddr[1] ? 4'b1100 : 4'b0011;
               wd_new = {2{i_writeData[15:0]}};
            end
            default: begin
               be_new = 4'b1111;
               wd_new = i_writeData;
            end
         endcase
      end
      to_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
      o_stall  = (state_q == S_REQ) | (state_q == S_WAIT_R)
               | ((state_q == S_IDLE) & access);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;
      fault_d = FAULT_NONE;
      f3_d    = f3_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (access) begin
               if (illegal) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  fault_d = FAULT_ILLEGAL;
               end else if (misalign) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  fault_d = FAULT_MISALIGN;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = is_wr;
                  addr_d  = {i_memAddr[ADDR_W-1:2], 2'b00};
                  wdata_d = wd_new;
                  be_d    = be_new;
                  f3_d    = i_funct3;
                  off_d   = i_memAddr[1:0];
                  cnt_d   = '0;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + 32'd1;
            if (i_memReady) begin
               req_d = 1'b0;
               we_d  = 1'b0;
               if (we_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_WAIT_R;
               end
            end else if (to_hit) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               state_d = S_DONE;
               done_d  = 1'b1;
               fault_d = FAULT_TIMEOUT;
               if (!we_q) rdata_d = '0;
            end
         end
         S_WAIT_R: begin
            cnt_d = cnt_q + 32'd1;
            if (i_memRvalid) begin
               rdata_d = ld_ext;
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (to_hit) begin
               rdata_d = '0;
               state_d = S_DONE;
               done_d  = 1'b1;
               fault_d = FAULT_TIMEOUT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         fault_q <= FAULT_NONE;
         f3_q    <= '0;
         off_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_memReq     = req_q;
   assign o_memWe      = we_q;
   assign o_memAddrOut = addr_q;
   assign o_memWdata   = wdata_q;
   assign o_memBe      = be_q;
   assign o_readData   = rdata_q;
   assign o_done       = done_q;
   assign o_fault      = fault_q;

endmodule
